// File: rtl/neuron_mac.sv
`timescale 1ns/1ps
// neuron_mac: sequential multiply-accumulate neuron stage producing one Q8.8
// pre-activation value, sum(x_i * w_i) + bias, over NUM_INPUTS streamed pairs.
// A wide accumulator holds Q.16 partial sums. A single rescale-and-saturate
// step produces the 16-bit Q8.8 result.
//
// Optional feature macro: ROUNDING_EN
//   defined   -> round half-up (+128 before the >>> 8)
//   undefined -> truncate (arithmetic shift, floor toward -infinity)
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin a neuron (sampled only in IDLE)
//   bias       signed Q8.8 bias, sampled with start
//   in_valid   input pair valid
//   in_ready   stage accepts a pair (state == ACCUM)
//   in_data    signed Q8.8 activation x_i
//   in_weight  signed Q8.8 weight w_i
//   out_valid  result valid (state == OUTPUT)
//   out_ready  downstream accepts the result
//   out_data   signed Q8.8 saturated result, held until the next result loads
//   overflow   result was clipped, held alongside out_data
//   busy       state is not IDLE
module neuron_mac #(
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_weight,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(NUM_INPUTS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [15:0]            out_data_q, out_data_d;
    logic                   overflow_q, overflow_d;

    logic signed [31:0]     product;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [ACC_WIDTH-1:0]   acc_conv;
    logic [ACC_WIDTH-1:0]   shifted;
    logic                   clip;
    logic [15:0]            clipped;
    logic                   beat;
    logic                   last_beat;

    // Q8.8 * Q8.8 -> Q16.16, sign-extended into the accumulator.
    assign product = $signed(in_data) * $signed(in_weight);
    assign acc_sum = acc_q + {{(ACC_WIDTH-32){product[31]}}, product};

`ifdef ROUNDING_EN
    assign acc_conv = acc_sum + ACC_WIDTH'(128);
`else
    assign acc_conv = acc_sum;
`endif

    assign shifted = $unsigned($signed(acc_conv) >>> 8);

    // Fits in 16 bits only if every bit above bit 15 copies the sign bit.
    assign clip    = (shifted[ACC_WIDTH-1:15] != {(ACC_WIDTH-15){shifted[ACC_WIDTH-1]}});
    assign clipped = clip ? (shifted[ACC_WIDTH-1] ? 16'h8000 : 16'h7FFF) : shifted[15:0];

    assign beat      = (state_q == StAccum) && in_valid;
    assign last_beat = (count_q == CntW'(NUM_INPUTS - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Bias Q8.8 << 8 aligns it with the Q.16 products.
                    acc_d   = {{(ACC_WIDTH-24){bias[15]}}, bias, 8'h00};
                    count_d = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (beat) begin
                    acc_d   = acc_sum;
                    count_d = count_q + CntW'(1);
                    if (last_beat) begin
                        out_data_d = clipped;
                        overflow_d = clip;
                        state_d    = StOutput;
                    end
                end
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            count_q    <= '0;
            out_data_q <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StOutput);
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_neuron_mac.sv
`timescale 1ns/1ps
module tb_neuron_mac;

    typedef struct packed {
        logic [15:0] d;
        logic        ov;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] in_weight = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    neuron_mac #(
        .NUM_INPUTS(4),
        .ACC_WIDTH (40)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_weight(in_weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference: exact integer arithmetic on the Q8.8 operands.
    function automatic exp_t model(input logic [15:0] b, input logic [3:0][15:0] xs,
                                   input logic [3:0][15:0] ws);
        longint acc;
        exp_t   e;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < 4; i++) begin
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        end
`ifdef ROUNDING_EN
        acc += 128;
`endif
        acc = acc >>> 8;
        if (acc > 32767) begin
            e.d = 16'h7FFF; e.ov = 1'b1;
        end else if (acc < -32768) begin
            e.d = 16'h8000; e.ov = 1'b1;
        end else begin
            e.d = acc[15:0]; e.ov = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one neuron up to the point out_valid is seen; out_ready is left low.
    // lat = cycles waited after the final beat (0 means out_valid right after it).
    task automatic do_neuron(input logic [15:0] b, input logic [3:0][15:0] xs,
                             input logic [3:0][15:0] ws, input bit gap,
                             output int lat, output logic [15:0] d, output logic ov);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = xs[i];
            in_weight = ws[i];
            tick();
            if (gap && i < 3) begin
                in_valid  = 1'b0;
                in_data   = 16'h7FFF;
                in_weight = 16'h7FFF;
                tick();
            end
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        d  = out_data;
        ov = overflow;
    endtask

    task automatic test_reset();
        #1;
        total += 5;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_and_check(input string name, input logic [15:0] b,
                                 input logic [3:0][15:0] xs, input logic [3:0][15:0] ws,
                                 input bit gap);
        int          lat;
        logic [15:0] d;
        logic        ov;
        exp_t        e;
        sb.push_back(model(b, xs, ws));
        do_neuron(b, xs, ws, gap, lat, d, ov);
        total += 3;
        if (lat != 0) begin bad++; $display("FAIL %s_latency got=%0d want=0", name, lat); end
        if (sb.size() == 0) begin
            bad += 2;
            $display("FAIL %s_scoreboard got=empty want=entry", name);
        end else begin
            e = sb.pop_front();
            if (d !== e.d) begin bad++; $display("FAIL %s_data got=%h want=%h", name, d, e.d); end
            if (ov !== e.ov) begin bad++; $display("FAIL %s_overflow got=%b want=%b", name, ov, e.ov); end
        end
    endtask

    task automatic handoff(input string name);
        logic [15:0] held;
        held = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_handoff_valid got=%b want=0", name, out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_handoff_busy got=%b want=0", name, busy); end
        if (out_data !== held) begin bad++; $display("FAIL %s_retain got=%h want=%h", name, out_data, held); end
    endtask

    task automatic test_nominal();
        run_and_check("nominal", 16'h0000, {4{16'h0100}}, {4{16'h0080}}, 1'b0);
        handoff("nominal");
    endtask

    task automatic test_saturation();
        run_and_check("sat_pos", 16'h7F00, {4{16'h7FFF}}, {4{16'h7FFF}}, 1'b0);
        handoff("sat_pos");
        run_and_check("sat_neg", 16'h8000, {4{16'h8000}}, {4{16'h7FFF}}, 1'b0);
        handoff("sat_neg");
    endtask

    task automatic test_rounding();
        run_and_check("round_pos", 16'h0000, {16'h0, 16'h0, 16'h0, 16'h0001},
                      {16'h0, 16'h0, 16'h0, 16'h0080}, 1'b0);
        handoff("round_pos");
        run_and_check("round_neg", 16'h0000, {16'h0, 16'h0, 16'h0, 16'hFFFF},
                      {16'h0, 16'h0, 16'h0, 16'h0080}, 1'b0);
        handoff("round_neg");
    endtask

    task automatic test_handshake();
        logic [15:0] held_d;
        logic        held_ov;
        run_and_check("gap", 16'h0010, {16'h0200, 16'hFF00, 16'h0180, 16'h0040},
                      {16'h0100, 16'h0300, 16'hFE80, 16'h0400}, 1'b1);
        held_d  = out_data;
        held_ov = overflow;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%b want=1", c, out_valid); end
            if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%b want=0", c, in_ready); end
            if (out_data !== held_d) begin bad++; $display("FAIL hold_data c=%0d got=%h want=%h", c, out_data, held_d); end
            if (overflow !== held_ov) begin bad++; $display("FAIL hold_ov c=%0d got=%b want=%b", c, overflow, held_ov); end
        end
        start = 1'b0;
        handoff("hold");
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_ignored_busy got=%b want=0", busy); end
    endtask

    task automatic test_ignored();
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'b1;
            in_data   = 16'h4000;
            in_weight = 16'h4000;
            tick();
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL idle_valid_busy c=%0d got=%b want=0", c, busy); end
        end
        in_valid = 1'b0;
        run_and_check("bias_only", 16'h0140, {4{16'h0000}}, {4{16'h1234}}, 1'b0);
        handoff("bias_only");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        bias  = 16'h0300;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'h0100;
            in_weight = 16'h0080;
            tick();
        end
        reset = 1'b1;
        #1;
        total += 5;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL midreset_data got=%h want=0000", out_data); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL midreset_ov got=%b want=0", overflow); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_and_check("after_reset", 16'h0000, {4{16'h0100}}, {4{16'h0080}}, 1'b0);
        handoff("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [3:0][15:0] xs;
        logic [3:0][15:0] ws;
        logic [15:0]      b;
        for (int n = 0; n < 6; n++) begin
            b = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                xs[i] = 16'($urandom);
                ws[i] = 16'($urandom_range(0, 16'h03FF));
                if (n[0]) ws[i] = -ws[i];
            end
            run_and_check("b2b", b, xs, ws, 1'b0);
            // Start is raised straight after the hand-off so it samples at H+1.
            handoff("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_rounding();
        test_handshake();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
